// File: rtl/ram_pkg.sv
// Shared FSM state type and address-width helper for the 2-read/1-write RAM.
package ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Init/run controller: zeroing sweep of one entry per cycle (DEPTH cycles), then RUN until clear.
// No backpressure; clear is only honoured in RUN, reset restarts the sweep from entry 0.
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_sweep_addr,
  output logic              o_sweep_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_sweep_cnt;
  logic [ADDR_W-1:0] w_sweep_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= INIT;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_cnt <= w_sweep_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_cnt_nxt = r_sweep_cnt;
    case (r_state)
      INIT: begin
        if (r_sweep_cnt == LAST_ADDR) begin
          w_state_nxt     = RUN;
          w_sweep_cnt_nxt = '0;
        end else begin
          w_sweep_cnt_nxt = r_sweep_cnt + 1'b1;
        end
      end
      RUN: begin
        if (i_clear) begin
          w_state_nxt     = INIT;
          w_sweep_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = INIT;
        w_sweep_cnt_nxt = '0;
      end
    endcase
  end

  assign o_ready      = (r_state == RUN);
  assign o_sweep_we   = (r_state == INIT);
  assign o_sweep_addr = r_sweep_cnt;

endmodule

// File: rtl/ram_2r1w.sv
// Two-read/one-write register-file RAM with zeroing sweep; reads are write-first, 1-cycle latency.
// No backpressure: accesses are dropped while ready is low (sweep in progress).
module ram_2r1w
  import ram_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              Write_Select,
  input  logic [ADDR_W-1:0] Write_Addr,
  input  logic [WIDTH-1:0]  Write_Data,
  input  logic              Read_Select_1,
  input  logic [ADDR_W-1:0] Read_Addr_1,
  input  logic              Read_Select_2,
  input  logic [ADDR_W-1:0] Read_Addr_2,
  output logic [WIDTH-1:0]  Read_Data_1,
  output logic [WIDTH-1:0]  Read_Data_2,
  output logic              Read_Valid_1,
  output logic              Read_Valid_2,
  output logic              ready
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_ready;
  logic              w_sweep_we;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              w_user_we;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [WIDTH-1:0]  w_mem_dat;
  logic [1:0]        w_rd_sel;
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [WIDTH-1:0]  w_rd_nxt  [2];
  logic [WIDTH-1:0]  r_rd_dat  [2];
  logic [1:0]        r_rd_vld;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return int'(addr) < DEPTH;
  endfunction

  ram_init_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_clear      (clear),
    .o_ready      (w_ready),
    .o_sweep_addr (w_sweep_addr),
    .o_sweep_we   (w_sweep_we)
  );

  // A clear cycle discards the user write; the sweep owns the array port in INIT.
  assign w_user_we  = w_ready & Write_Select & ~clear & in_range(Write_Addr);
  assign w_mem_we   = w_sweep_we | w_user_we;
  assign w_mem_addr = w_sweep_we ? w_sweep_addr : Write_Addr;
  assign w_mem_dat  = w_sweep_we ? '0 : Write_Data;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_dat;
    end
  end

  assign w_rd_sel     = {Read_Select_2, Read_Select_1};
  assign w_rd_addr[0] = Read_Addr_1;
  assign w_rd_addr[1] = Read_Addr_2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_nxt[p] = '0;
      if (!in_range(w_rd_addr[p])) begin
        w_rd_nxt[p] = '0;
      end else if (w_user_we && (Write_Addr == w_rd_addr[p])) begin
        w_rd_nxt[p] = Write_Data;
      end else begin
        w_rd_nxt[p] = r_mem[w_rd_addr[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld <= '0;
      for (int p = 0; p < 2; p++) begin
        r_rd_dat[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_rd_vld[p] <= w_ready & w_rd_sel[p];
        if (w_ready && w_rd_sel[p]) begin
          r_rd_dat[p] <= w_rd_nxt[p];
        end
      end
    end
  end

  assign Read_Data_1  = r_rd_dat[0];
  assign Read_Data_2  = r_rd_dat[1];
  assign Read_Valid_1 = r_rd_vld[0];
  assign Read_Valid_2 = r_rd_vld[1];
  assign ready        = w_ready;

endmodule

// File: tb/tb_ram_2r1w.sv
// Scoreboard bench for ram_2r1w: one DEPTH=16 and one DEPTH=12 instance on a shared clock.
`timescale 1ns/1ps
module tb_ram_2r1w;

  typedef struct packed {
    logic       clr;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       rs1;
    logic [3:0] ra1;
    logic       rs2;
    logic [3:0] ra2;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_clr = 1'b0, a_we = 1'b0, a_rs1 = 1'b0, a_rs2 = 1'b0;
  logic [3:0] a_wa = '0, a_ra1 = '0, a_ra2 = '0;
  logic [7:0] a_wd = '0;
  logic [7:0] a_rd1, a_rd2;
  logic       a_rv1, a_rv2, a_rdy;

  logic       b_rst = 1'b1, b_clr = 1'b0, b_we = 1'b0, b_rs1 = 1'b0, b_rs2 = 1'b0;
  logic [3:0] b_wa = '0, b_ra1 = '0, b_ra2 = '0;
  logic [7:0] b_wd = '0;
  logic [7:0] b_rd1, b_rd2;
  logic       b_rv1, b_rv2, b_rdy;

  ram_2r1w #(.WIDTH(8), .DEPTH(16)) dut16 (
    .clk(clk), .reset(a_rst), .clear(a_clr),
    .Write_Select(a_we), .Write_Addr(a_wa), .Write_Data(a_wd),
    .Read_Select_1(a_rs1), .Read_Addr_1(a_ra1),
    .Read_Select_2(a_rs2), .Read_Addr_2(a_ra2),
    .Read_Data_1(a_rd1), .Read_Data_2(a_rd2),
    .Read_Valid_1(a_rv1), .Read_Valid_2(a_rv2), .ready(a_rdy)
  );

  ram_2r1w #(.WIDTH(8), .DEPTH(12)) dut12 (
    .clk(clk), .reset(b_rst), .clear(b_clr),
    .Write_Select(b_we), .Write_Addr(b_wa), .Write_Data(b_wd),
    .Read_Select_1(b_rs1), .Read_Addr_1(b_ra1),
    .Read_Select_2(b_rs2), .Read_Addr_2(b_ra2),
    .Read_Data_1(b_rd1), .Read_Data_2(b_rd2),
    .Read_Valid_1(b_rv1), .Read_Valid_2(b_rv2), .ready(b_rdy)
  );

  logic       use_b = 1'b0;
  int         depth = 16;
  logic [7:0] rd1, rd2;
  logic       rv1, rv2, rdy;
  assign rd1 = use_b ? b_rd1 : a_rd1;
  assign rd2 = use_b ? b_rd2 : a_rd2;
  assign rv1 = use_b ? b_rv1 : a_rv1;
  assign rv2 = use_b ? b_rv2 : a_rv2;
  assign rdy = use_b ? b_rdy : a_rdy;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] m [16];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic [7:0] last1, last2;
  logic       v1, v2;

  function automatic op_t mk(input int we, input int wa, input int wd, input int rs1,
                             input int ra1, input int rs2, input int ra2, input int clr);
    op_t o;
    o.we = 1'(we); o.wa = 4'(wa); o.wd = 8'(wd); o.rs1 = 1'(rs1);
    o.ra1 = 4'(ra1); o.rs2 = 1'(rs2); o.ra2 = 4'(ra2); o.clr = 1'(clr);
    return o;
  endfunction

  function automatic logic [7:0] exp_rd(input op_t o, input logic [3:0] ra);
    if (int'(ra) >= depth) return 8'h00;
    if (o.we && !o.clr && o.wa == ra) return o.wd;
    return m[ra];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rst(input logic v);
    if (use_b) b_rst = v;
    else a_rst = v;
  endtask

  task automatic drive(input op_t o);
    if (use_b) begin
      b_clr = o.clr; b_we = o.we; b_wa = o.wa; b_wd = o.wd;
      b_rs1 = o.rs1; b_ra1 = o.ra1; b_rs2 = o.rs2; b_ra2 = o.ra2;
    end else begin
      a_clr = o.clr; a_we = o.we; a_wa = o.wa; a_wd = o.wd;
      a_rs1 = o.rs1; a_ra1 = o.ra1; a_rs2 = o.rs2; a_ra2 = o.ra2;
    end
  endtask

  task automatic model_zero();
    for (int j = 0; j < 16; j++) m[j] = 8'h00;
    q1.delete(); q2.delete();
    last1 = 8'h00; last2 = 8'h00;
  endtask

  // Drive one RUN-state cycle and push the expected read results.
  task automatic issue(input op_t o);
    @(negedge clk);
    drive(o);
    if (o.rs1) q1.push_back(exp_rd(o, o.ra1));
    if (o.rs2) q2.push_back(exp_rd(o, o.ra2));
    if (o.clr) begin
      for (int j = 0; j < 16; j++) m[j] = 8'h00;
    end else if (o.we && int'(o.wa) < depth) begin
      m[o.wa] = o.wd;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_rst(1'b1);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) cyc();
    n_chk++;
    if (rdy !== 1'b0 || rv1 !== 1'b0 || rv2 !== 1'b0 || rd1 !== 8'h00 || rd2 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b v1=%b v2=%b d1=%h d2=%h, want all zero", rdy, rv1, rv2, rd1, rd2);
    end
    @(negedge clk);
    set_rst(1'b0);
    drive(mk(1, 5, 8'h77, 1, 5, 1, 5, 1));
    for (int k = 1; k <= depth; k++) begin
      cyc();
      n_chk++;
      if (rdy !== (k == depth) || rv1 !== 1'b0 || rv2 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_sweep cycle %0d: rdy=%b v1=%b v2=%b, want rdy=%b v1=0 v2=0", k, rdy, rv1, rv2, (k == depth));
      end
    end
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    model_zero();
  endtask

  task automatic test_read_all();
    op_t ops [$];
    for (int a = 0; a < depth; a++) ops.push_back(mk(0, 0, 0, 1, a, 1, depth - 1 - a, 0));
    ops.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (ops[i]) begin
      issue(ops[i]);
      cyc();
      v1 = (q1.size() != 0); if (v1) last1 = q1.pop_front();
      v2 = (q2.size() != 0); if (v2) last2 = q2.pop_front();
      n_chk++;
      if (rv1 !== v1 || rd1 !== last1 || rv2 !== v2 || rd2 !== last2) begin
        n_fail++;
        $display("FAIL read_all op%0d: got v1=%b d1=%h v2=%b d2=%h, want v1=%b d1=%h v2=%b d2=%h", i, rv1, rd1, rv2, rd2, v1, last1, v2, last2);
      end
    end
  endtask

  task automatic test_write_read();
    op_t ops [$];
    ops.push_back(mk(1, 3, 8'hA5, 0, 0, 0, 0, 0));
    ops.push_back(mk(0, 0, 0, 1, 3, 1, 3, 0));
    ops.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    ops.push_back(mk(0, 0, 0, 0, 9, 1, 3, 0));
    ops.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (ops[i]) begin
      issue(ops[i]);
      cyc();
      v1 = (q1.size() != 0); if (v1) last1 = q1.pop_front();
      v2 = (q2.size() != 0); if (v2) last2 = q2.pop_front();
      n_chk++;
      if (rv1 !== v1 || rd1 !== last1 || rv2 !== v2 || rd2 !== last2) begin
        n_fail++;
        $display("FAIL write_read op%0d: got v1=%b d1=%h v2=%b d2=%h, want v1=%b d1=%h v2=%b d2=%h", i, rv1, rd1, rv2, rd2, v1, last1, v2, last2);
      end
    end
  endtask

  task automatic test_bypass();
    op_t ops [$];
    ops.push_back(mk(1, 6, 8'h66, 0, 0, 0, 0, 0));
    ops.push_back(mk(1, 7, 8'h3C, 1, 7, 1, 6, 0));
    ops.push_back(mk(1, 6, 8'h99, 1, 7, 1, 6, 0));
    ops.push_back(mk(0, 0, 0, 1, 6, 0, 0, 0));
    ops.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (ops[i]) begin
      issue(ops[i]);
      cyc();
      v1 = (q1.size() != 0); if (v1) last1 = q1.pop_front();
      v2 = (q2.size() != 0); if (v2) last2 = q2.pop_front();
      n_chk++;
      if (rv1 !== v1 || rd1 !== last1 || rv2 !== v2 || rd2 !== last2) begin
        n_fail++;
        $display("FAIL bypass op%0d: got v1=%b d1=%h v2=%b d2=%h, want v1=%b d1=%h v2=%b d2=%h", i, rv1, rd1, rv2, rd2, v1, last1, v2, last2);
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t ops [$];
    for (int a = 0; a < 16; a++) ops.push_back(mk(1, a, a * 13 + 5, 1, a, 1, (a + 15) % 16, 0));
    ops.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (ops[i]) begin
      issue(ops[i]);
      cyc();
      v1 = (q1.size() != 0); if (v1) last1 = q1.pop_front();
      v2 = (q2.size() != 0); if (v2) last2 = q2.pop_front();
      n_chk++;
      if (rv1 !== v1 || rd1 !== last1 || rv2 !== v2 || rd2 !== last2) begin
        n_fail++;
        $display("FAIL back_to_back op%0d: got v1=%b d1=%h v2=%b d2=%h, want v1=%b d1=%h v2=%b d2=%h", i, rv1, rd1, rv2, rd2, v1, last1, v2, last2);
      end
    end
  endtask

  task automatic test_clear();
    issue(mk(1, 0, 8'hFF, 1, 0, 1, 5, 1));
    cyc();
    v1 = (q1.size() != 0); if (v1) last1 = q1.pop_front();
    v2 = (q2.size() != 0); if (v2) last2 = q2.pop_front();
    n_chk++;
    if (rv1 !== v1 || rd1 !== last1 || rv2 !== v2 || rd2 !== last2 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_cycle: got v1=%b d1=%h v2=%b d2=%h rdy=%b, want v1=%b d1=%h v2=%b d2=%h rdy=0", rv1, rd1, rv2, rd2, rdy, v1, last1, v2, last2);
    end
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= depth; k++) begin
      cyc();
      n_chk++;
      if (rdy !== (k == depth) || rv1 !== 1'b0 || rv2 !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_sweep cycle %0d: rdy=%b v1=%b v2=%b, want rdy=%b", k, rdy, rv1, rv2, (k == depth));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_rst(1'b1);
    drive(mk(0, 0, 0, 1, 3, 1, 4, 0));
    cyc();
    n_chk++;
    if (rdy !== 1'b0 || rv1 !== 1'b0 || rv2 !== 1'b0 || rd1 !== 8'h00 || rd2 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_access: rdy=%b v1=%b v2=%b d1=%h d2=%h, want all zero", rdy, rv1, rv2, rd1, rd2);
    end
    @(negedge clk);
    set_rst(1'b0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (depth) cyc();
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1));
    cyc();
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (5) cyc();
    @(negedge clk);
    set_rst(1'b1);
    cyc();
    @(negedge clk);
    set_rst(1'b0);
    for (int k = 1; k <= depth; k++) begin
      cyc();
      n_chk++;
      if (rdy !== (k == depth) || rv1 !== 1'b0 || rv2 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_sweep cycle %0d: rdy=%b v1=%b v2=%b, want rdy=%b", k, rdy, rv1, rv2, (k == depth));
      end
    end
    model_zero();
  endtask

  task automatic test_out_of_range();
    op_t ops [$];
    ops.push_back(mk(1, 13, 8'h11, 0, 0, 0, 0, 0));
    ops.push_back(mk(1, 2, 8'h5A, 1, 13, 1, 2, 0));
    ops.push_back(mk(1, 11, 8'hE7, 1, 13, 1, 12, 0));
    ops.push_back(mk(1, 13, 8'h22, 1, 13, 1, 11, 0));
    ops.push_back(mk(0, 0, 0, 1, 15, 0, 0, 0));
    ops.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (ops[i]) begin
      issue(ops[i]);
      cyc();
      v1 = (q1.size() != 0); if (v1) last1 = q1.pop_front();
      v2 = (q2.size() != 0); if (v2) last2 = q2.pop_front();
      n_chk++;
      if (rv1 !== v1 || rd1 !== last1 || rv2 !== v2 || rd2 !== last2) begin
        n_fail++;
        $display("FAIL out_of_range op%0d: got v1=%b d1=%h v2=%b d2=%h, want v1=%b d1=%h v2=%b d2=%h", i, rv1, rd1, rv2, rd2, v1, last1, v2, last2);
      end
    end
  endtask

  initial begin
    model_zero();
    use_b = 1'b0;
    depth = 16;
    test_reset();
    test_read_all();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_clear();
    test_read_all();
    test_reset_mid();
    test_read_all();

    use_b = 1'b1;
    depth = 12;
    test_reset();
    test_out_of_range();
    test_read_all();
    test_reset_mid();
    test_read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
